tx_channel: RTL and testbench
=============================

# tx_channel

Transmit end of a single AXI valid/ready channel and the counterpart of the receive channel block. It accepts words from an upper module through a simple push interface, buffers them in a small FIFO, and drives VALID/xDATA onto the bus. It obeys AXI source rules: VALID is never gated by READY, and data is held stable until the handshake. One instance sits on each master-to-slave channel (AW/W/AR payloads) or slave-to-master channel (R/B payloads) of the AXI-Lite wrapper.

## Interface
- WIDTH, 8, payload width in bits
- DEPTH, 2, FIFO entries; power of two, ≥2
- ACLK  in  1  clock; all state updates on posedge
- ARESETn  in  1  reset, asynchronous, active-low
- VALID  out  1  bus valid; registered
- READY  in  1  bus ready from sink
- xDATA  out  WIDTH  bus payload; registered, equals FIFO head
- tx_data  in  WIDTH  word from upper module
- tx_push  in  1  write strobe for tx_data
- tx_full  out  1  FIFO holds DEPTH words; push ignored
- tx_level  out  $clog2(DEPTH+1)  words currently buffered, including the one on the bus
- tx_done  out  1  one-cycle pulse after each completed handshake

## Operation
- FIFO: rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH; tx_level is the count register.
- A push is accepted at a posedge when tx_push=1 and tx_full=0. A push while tx_full=1 is dropped silently, even if a pop occurs on the same edge; the upper module must check tx_full.
- State machine (tx_state_t): IDLE and SEND.
  - IDLE: VALID=0. Go to SEND at the edge where the pre-edge tx_level≠0.
  - SEND: VALID=1, xDATA=mem[rd_ptr]. A handshake is VALID&&READY at the posedge.
  - On handshake: pop the head and pulse tx_done the next cycle. Stay in SEND if the post-edge level is >0 (a simultaneous push counts). Otherwise go to IDLE.
  - SEND without a handshake: hold state, VALID and xDATA unchanged. This is an AXI stability requirement, so xDATA must not change while VALID=1 and READY=0.
- Simultaneous push and pop (not full): level is unchanged and both pointers advance.
- READY may be asserted before VALID. READY while IDLE has no effect.
- tx_done is asserted for one cycle per handshake. Back-to-back handshakes produce consecutive tx_done=1 cycles.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, VALID=0, xDATA=0, tx_level=0, tx_full=0, tx_done=0, pointers=0. FIFO contents are don't-care.
- Reset mid-transfer drops VALID immediately and flushes all buffered words. No handshake is completed.
- Latency: a push at edge N from empty gives VALID=1 after edge N+1.
- Throughput: one word per cycle while the FIFO is non-empty and READY=1. VALID stays high across back-to-back transfers, with no bubble.
- After the handshake at edge M that empties the FIFO, VALID=0 after edge M.
- tx_full and tx_level update on the same edge as the push or pop that changes them.

## Structure
- Shared package axi_pkg: tx_state_t enum {IDLE, SEND}, declared logic-typed. Place it beside the existing channel typedefs.
- One sub-module, tx_fifo: storage array, pointers, count, full/empty. Interface: push, pop, wdata, rdata, level, full, empty.
- tx_channel holds the FSM, the VALID/xDATA output registers and tx_done. Pop = (state==SEND) && READY.

## Test plan
- Single word: after reset, push 0xA5 with READY=1. Required: VALID=1 and xDATA=0xA5 for exactly one cycle, then tx_done pulses once, VALID=0 and tx_level=0.
- Backpressure: push 0x3C with READY=0 for 5 cycles, then READY=1. Required: VALID and xDATA=0x3C stable for all 5 stalled cycles, then one handshake.
- Burst: push 0x01 and 0x02 on consecutive cycles with READY=1. Required: xDATA shows 0x01 then 0x02 on consecutive cycles with no VALID drop, and two tx_done pulses.
- Full/drop: with READY=0, push 0x11, 0x22, 0x33. Required: tx_full=1 after the second push, 0x33 is dropped, and after READY=1 only 0x11 and 0x22 appear.
- Simultaneous push and pop at level 1: tx_level stays 1, order is preserved, and VALID stays high.
- Reset mid-stall: with VALID=1 and READY=0, pulse ARESETn low. Required: VALID=0 immediately, tx_level=0, and no word is sent after release.

Source files
------------

// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_pkg
// Purpose  : Shared typedefs for the AXI-Lite channel blocks.
// Revision : 1.0 - initial release
// ============================================================================
package axi_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tx_fifo
// Purpose  : Small power-of-two FIFO feeding the transmit channel registers.
// Revision : 1.0 - initial release
// ============================================================================
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [WIDTH-1:0]             rdata_nxt,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];
    // Head after a pop: the next stored word, or the word being pushed when
    // the FIFO is about to drain to zero on the same edge.
    assign rdata_nxt = (level_q > LW'(1)) ? mem_q[rd_ptr_q + AW'(1)] : wdata;

    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tx_channel.sv
`default_nettype none
// ============================================================================
// Module   : tx_channel
// Purpose  : AXI valid/ready source: push interface -> FIFO -> VALID/xDATA.
// Revision : 1.0 - initial release
// ============================================================================
module tx_channel
    import axi_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    output logic                         VALID,
    input  logic                         READY,
    output logic [WIDTH-1:0]             xDATA,
    input  logic [WIDTH-1:0]             tx_data,
    input  logic                         tx_push,
    output logic                         tx_full,
    output logic [$clog2(DEPTH+1)-1:0]   tx_level,
    output logic                         tx_done
);

    localparam int LW = $clog2(DEPTH + 1);

    tx_state_t        state_q, state_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] xdata_q, xdata_d;
    logic             done_q,  done_d;
    logic             pop;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rdata;
    logic [WIDTH-1:0] fifo_rdata_nxt;

    assign pop = (state_q == SEND) && READY && !fifo_empty;

    tx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .push      (tx_push),
        .pop       (pop),
        .wdata     (tx_data),
        .rdata     (fifo_rdata),
        .rdata_nxt (fifo_rdata_nxt),
        .level     (tx_level),
        .full      (tx_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        xdata_d = xdata_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_level != LW'(0)) begin
                    state_d = SEND;
                    valid_d = 1'b1;
                    xdata_d = fifo_rdata;
                end
            end
            SEND: begin
                // Without a handshake nothing moves, keeping xDATA stable.
                if (pop) begin
                    done_d = 1'b1;
                    if ((tx_level > LW'(1)) || (tx_push && !tx_full)) begin
                        xdata_d = fifo_rdata_nxt;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            xdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            xdata_q <= xdata_d;
            done_q  <= done_d;
        end
    end

    assign VALID   = valid_q;
    assign xDATA   = xdata_q;
    assign tx_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_channel.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_channel
// Purpose  : Directed and random stimulus for tx_channel against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_channel;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int LW    = $clog2(DEPTH + 1);

    logic             ACLK    = 1'b0;
    logic             ARESETn = 1'b0;
    logic             READY   = 1'b0;
    logic             tx_push = 1'b0;
    logic [WIDTH-1:0] tx_data = '0;
    logic             VALID;
    logic [WIDTH-1:0] xDATA;
    logic             tx_full;
    logic [LW-1:0]    tx_level;
    logic             tx_done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: buffered words in order, plus bus-side valid/done flags.
    logic [WIDTH-1:0] q[$];
    bit               m_valid = 1'b0;
    bit               m_done  = 1'b0;

    tx_channel #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .VALID    (VALID),
        .READY    (READY),
        .xDATA    (xDATA),
        .tx_data  (tx_data),
        .tx_push  (tx_push),
        .tx_full  (tx_full),
        .tx_level (tx_level),
        .tx_done  (tx_done)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        m_done  = 1'b0;
    endtask

    task automatic model_step();
        int pre;
        bit hs;
        pre = q.size();
        hs  = m_valid && READY;
        if (hs) void'(q.pop_front());
        if (tx_push && (pre < DEPTH)) q.push_back(tx_data);
        m_done = hs;
        if (m_valid) m_valid = hs ? (q.size() > 0) : 1'b1;
        else         m_valid = (pre > 0);
    endtask

    task automatic compare_all();
        chk("VALID", {31'd0, VALID}, {31'd0, m_valid});
        if (m_valid) chk("xDATA", {24'd0, xDATA}, {24'd0, q[0]});
        chk("tx_level", {30'd0, tx_level}, q.size());
        chk("tx_full", {31'd0, tx_full}, {31'd0, q.size() == DEPTH});
        chk("tx_done", {31'd0, tx_done}, {31'd0, m_done});
    endtask

    task automatic cycle(input bit p, input logic [WIDTH-1:0] d, input bit r);
        tx_push = p;
        tx_data = d;
        READY   = r;
        @(posedge ACLK);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        #12;
        chk("rst_VALID", {31'd0, VALID}, 32'd0);
        chk("rst_xDATA", {24'd0, xDATA}, 32'd0);
        chk("rst_level", {30'd0, tx_level}, 32'd0);
        chk("rst_full", {31'd0, tx_full}, 32'd0);
        chk("rst_done", {31'd0, tx_done}, 32'd0);
        model_reset();
        ARESETn = 1'b1;

        // Single word
        cycle(1'b1, 8'hA5, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("single_data", {24'd0, xDATA}, 32'hA5);
        cycle(1'b0, 8'h00, 1'b1);
        chk("single_done", {31'd0, tx_done}, 32'd1);
        chk("single_idle", {31'd0, VALID}, 32'd0);
        cycle(1'b0, 8'h00, 1'b1);

        // Backpressure
        cycle(1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
            chk("bp_stable", {24'd0, xDATA}, 32'h3C);
        end
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);

        // Burst
        cycle(1'b1, 8'h01, 1'b1);
        cycle(1'b1, 8'h02, 1'b1);
        chk("burst_first", {24'd0, xDATA}, 32'h01);
        cycle(1'b0, 8'h00, 1'b1);
        chk("burst_second", {24'd0, xDATA}, 32'h02);
        for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00, 1'b1);

        // Full / drop
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        chk("full_set", {31'd0, tx_full}, 32'd1);
        cycle(1'b1, 8'h33, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);

        // Simultaneous push and pop at level 1
        cycle(1'b1, 8'h44, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h55, 1'b1);
        chk("pp_level", {30'd0, tx_level}, 32'd1);
        cycle(1'b1, 8'h66, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);

        // Reset mid-stall
        cycle(1'b1, 8'h77, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        #2;
        ARESETn = 1'b0;
        #1;
        chk("arst_VALID", {31'd0, VALID}, 32'd0);
        chk("arst_level", {30'd0, tx_level}, 32'd0);
        model_reset();
        #3;
        ARESETn = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 9) < 6, WIDTH'($urandom), $urandom_range(0, 9) < 6);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
